cone_exh_checker: RTL

- Sequential controller that drives every input pattern (0 .. 2^N_IN-1) into a combinational logic cone under test and into a golden cone, then compares the two single-bit responses.
- Used in equivalence regressions of synthesized netlists against their original.
- Reports a mismatch count, the first failing pattern and a 16-bit response signature.
- Sits between the bench/host control and the two cone instances, which are external to this block.

---
 rtl/cone_chk_pkg.sv | 23 ++
 rtl/cone_exh_checker_sig_lfsr.sv | 24 ++
 rtl/cone_exh_checker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cone_chk_pkg.sv
// Shared types and constants for the exhaustive cone equivalence checker.
// Also holds the signature step function used by the signature register.
package cone_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] SIG_POLY = 16'h1021;
    localparam logic [15:0] SIG_SEED = 16'hFFFF;
    localparam int          LAT_MAX  = 7;

    // One Galois step: shift left and fold in the polynomial when the feedback bit is set.
    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic d);
        logic fb;
        fb = s[15] ^ d;
        return {s[14:0], 1'b0} ^ (fb ? SIG_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cone_exh_checker_sig_lfsr.sv
// 16-bit Galois signature register compacting the cone-under-test response stream.
// The seed is loaded on reset and on load; shift folds in one response bit.
module sig_lfsr
    import cone_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic        din,
    output logic [15:0] sig
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= SIG_SEED;
        end else if (load) begin
            sig <= SIG_SEED;
        end else if (shift) begin
            sig <= sig_step(sig, din);
        end
    end

endmodule

// File: rtl/cone_exh_checker.sv
// Exhaustive equivalence checker: sweeps every pattern into two external cones,
// compares the responses LAT cycles later and records errors and a signature.
module cone_exh_checker
    import cone_chk_pkg::*;
#(
    parameter int N_IN = 10,
    parameter int LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    output logic [N_IN-1:0] pat_o,
    input  logic            dut_o,
    input  logic            ref_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            aborted,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld,
    output logic [15:0]     sig
);

    localparam int              DW         = $clog2(LAT_MAX + 1);
    localparam logic [N_IN-1:0] PAT_MAX    = '1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(LAT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   drain_cnt;
    logic            start_ok;
    logic            stop_ok;
    logic            smp_vld;
    logic [N_IN-1:0] smp_pat;
    logic            sample;
    logic            mismatch;

    assign start_ok = start && !stop && (state == IDLE || state == DONE);
    assign stop_ok  = stop && (state == RUN || state == DRAIN);
    // A sample coinciding with an abort is treated as in flight and dropped.
    assign sample   = smp_vld && busy && !stop_ok;
    assign mismatch = dut_o != ref_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (pat_o == PAT_MAX) begin
                    state_nxt = (LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
        pass = (state == DONE) && (err_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    // The pipe tracks which pattern each in-flight response belongs to.
    generate
        if (LAT > 0) begin : g_pipe
            logic [LAT-1:0]  vld_q;
            logic [N_IN-1:0] pat_q [LAT];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        pat_q[i] <= '0;
                    end
                end else if (start_ok || stop_ok) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= (state == RUN);
                    pat_q[0] <= pat_o;
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        pat_q[i] <= pat_q[i-1];
                    end
                end
            end

            assign smp_vld = vld_q[LAT-1];
            assign smp_pat = pat_q[LAT-1];
        end else begin : g_nopipe
            assign smp_vld = (state == RUN);
            assign smp_pat = pat_o;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_o          <= '0;
            aborted        <= 1'b0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (start_ok) begin
            pat_o          <= '0;
            aborted        <= 1'b0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            if (stop_ok) begin
                aborted <= 1'b1;
            end else if (state == RUN && pat_o != PAT_MAX) begin
                pat_o <= pat_o + 1'b1;
            end
            // Patterns arrive in ascending order, so the first capture is the lowest failure.
            if (sample && mismatch) begin
                err_cnt <= err_cnt + 1'b1;
                if (!first_fail_vld) begin
                    first_fail     <= smp_pat;
                    first_fail_vld <= 1'b1;
                end
            end
        end
    end

    sig_lfsr u_sig (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .shift (sample),
        .din   (dut_o),
        .sig   (sig)
    );

endmodule
